// File: rtl/fetch_stage.sv
// fetch_stage: RV32 fetch with PC, 2-deep instruction buffer, redirect/discard and decode stall handling
module fetch_stage #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        next_pc_en,
   input  logic [31:0] next_pc,
   input  logic        bubble_fetch,
   input  logic        stall_decode,
   output logic        ibus_req,
   output logic [31:0] ibus_addr,
   input  logic        ibus_gnt,
   input  logic        ibus_rvalid,
   input  logic [31:0] ibus_rdata,
   input  logic        ibus_err,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_fault
);
   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] pc;
      logic        fault;
   } entry_t;

   logic [31:0] pc, aq0, aq1;
   entry_t      e0, e1, e_new;
   logic [1:0]  count, inflight, discard, slot, aslot;
   logic        pop, push, gnt;

   // e0 is always the buffer head; it keeps its last value once the buffer drains
   assign inst_valid = (count != 2'd0) & ~bubble_fetch & ~next_pc_en;
   assign inst       = e0.rdata;
   assign inst_pc    = e0.pc;
   assign inst_fault = e0.fault;
   assign pop        = inst_valid & ~stall_decode;
   // a request is only offered when its response is guaranteed a buffer slot
   assign ibus_req   = rst_n & ~next_pc_en & ((3'(inflight) + 3'(count) - 3'(pop)) < 3'd2);
   assign ibus_addr  = pc;
   assign gnt        = ibus_req & ibus_gnt;
   assign push       = ibus_rvalid & (discard == 2'd0) & ~next_pc_en;
   assign slot       = count - 2'(pop);
   assign aslot      = inflight - 2'(ibus_rvalid);
   assign e_new      = '{ibus_rdata, aq0, ibus_err};

   // PC, shift-style instruction buffer, in-order address queue and discard bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_ADDR;
         count    <= 2'd0;
         e0       <= '{32'h0000_0013, RESET_ADDR, 1'b0};
         e1       <= '0;
         inflight <= 2'd0;
         aq0      <= RESET_ADDR;
         aq1      <= RESET_ADDR;
         discard  <= 2'd0;
      end else begin
         pc       <= next_pc_en ? {next_pc[31:2], 2'b00} : gnt ? pc + 32'd4 : pc;
         count    <= next_pc_en ? 2'd0 : slot + 2'(push);
         e0       <= (push && slot == 2'd0) ? e_new : (pop && count == 2'd2) ? e1 : e0;
         e1       <= (push && slot == 2'd1) ? e_new : e1;
         inflight <= aslot + 2'(gnt);
         aq0      <= (gnt && aslot == 2'd0) ? pc : (ibus_rvalid && inflight == 2'd2) ? aq1 : aq0;
         aq1      <= (gnt && aslot == 2'd1) ? pc : aq1;
         discard  <= next_pc_en ? aslot : discard - 2'(ibus_rvalid && discard != 2'd0);
      end
   end

   // a response with nothing outstanding means the bus broke ordering/handshake
   a_rvalid_inflight : assert property (@(posedge clk) disable iff (!rst_n) ibus_rvalid |-> inflight != 2'd0);
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RV32 core pipeline, directly upstream of the pipeline control unit and the decode stage. Owns the program counter, issues word fetches on the instruction bus, buffers up to two returned instructions, and presents them to decode. Applies redirects (branch / trap target) and fetch bubbles from the control unit, and decode stalls, without losing or duplicating instructions.

## Interface
- `RESET_ADDR`, `32'h0000_0000`: PC value after reset; bits [1:0] must be 0.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `next_pc_en` in 1: redirect strobe from control.
- `next_pc` in 32: redirect target; bits [1:0] ignored (treated as 0).
- `bubble_fetch` in 1: from control; withhold the instruction from decode this cycle.
- `stall_decode` in 1: from control; decode holds its current instruction.
- `ibus_req` out 1: fetch request offer.
- `ibus_addr` out 32: fetch word address.
- `ibus_gnt` in 1: request accepted this cycle; meaningful only when `ibus_req`=1.
- `ibus_rvalid` in 1: response valid; responses return in request order.
- `ibus_rdata` in 32: instruction word.
- `ibus_err` in 1: access fault on this response; qualified by `ibus_rvalid`.
- `inst_valid` out 1: `inst`/`inst_pc`/`inst_fault` valid to decode (decode bubbles when 0).
- `inst` out 32: instruction word.
- `inst_pc` out 32: address of `inst`.
- `inst_fault` out 1: instruction fetch access fault for `inst`.

## Operation
- State: `pc` (32), instruction buffer FIFO of depth 2 (entry = {rdata, pc, fault}), `inflight` counter 0..2, `discard` counter 0..2.
- Buffer entry pc is recorded at grant: a 2-deep in-order address queue parallel to `inflight`.
- `pop` = `inst_valid` & !`stall_decode`.
- `inst_valid` = (buffer count > 0) & !`bubble_fetch` & !`next_pc_en`. `inst`/`inst_pc`/`inst_fault` always show the buffer head (hold last value when empty).
- `ibus_req` = !`next_pc_en` & (`inflight` + count − `pop` < 2). `ibus_addr` = `pc`.
- Request is a single-cycle offer: no hold requirement; address/req may change on any cycle without `ibus_gnt`.
- On `ibus_req` & `ibus_gnt`: `pc` <= `pc` + 4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000); `inflight` increments.
- On `ibus_rvalid`: `inflight` decrements; if `discard` > 0, response dropped and `discard` decrements; else entry {`ibus_rdata`, queued pc, `ibus_err`} pushed.
- `bubble_fetch` without `next_pc_en`: head not popped, nothing lost; fetching continues up to credit limit.
- `next_pc_en` (redirect): `pc` <= {`next_pc`[31:2],2'b00}; buffer flushed (count <= 0); `discard` <= `inflight` − (`ibus_rvalid`?1:0) + current `discard` adjustments, i.e. every response not yet returned at end of this cycle is discarded; the `ibus_rvalid` arriving in the redirect cycle is dropped. No request in the redirect cycle.
- Simultaneous push and pop: count unchanged; ordering preserved.
- `stall_decode` with `bubble_fetch`: `inst_valid`=0, no pop.
- `inflight` and `discard` never exceed 2; `ibus_rvalid` with `inflight`=0 is a protocol violation (assertion).

## Timing
- Reset (async assert, sync release): `pc`=RESET_ADDR, buffer empty, `inflight`=`discard`=0; outputs `ibus_req`=0 while `rst_n`=0, `ibus_addr`=RESET_ADDR, `inst_valid`=0, `inst`=32'h0000_0013, `inst_pc`=RESET_ADDR, `inst_fault`=0.
- First `ibus_req` in the first cycle after reset release.
- Latency: grant cycle N, `ibus_rvalid` ≥ N+1, `inst_valid` at rvalid+1 (buffer registered, no bypass).
- Throughput: 1 instruction/cycle sustained with 1-cycle bus and no stalls.
- Redirect at cycle R: `ibus_addr`=target and `ibus_req` eligible at R+1; first target instruction at `inst_valid` ≥ R+3 with 1-cycle bus.
- Reset asserted mid-transaction: all state cleared immediately; stale responses after release are not expected (bus resets together).

## Test plan
- Reset release, bus gnt/rvalid 1-cycle, memory word = address: `ibus_addr` 0,4,8,... one per cycle; `inst_valid` from cycle 3, `inst_pc`=`inst`=0,4,8 consecutive.
- `stall_decode`=1 for 5 cycles mid-stream: `inst` holds, buffer fills to 2, `ibus_req`=0 once `inflight`+count=2; release resumes with no lost/duplicated pc.
- Redirect to 0x0000_0100 with 2 in flight, responses returning at R+1, R+2: both dropped, next `inst_pc`=0x100, then 0x104.
- `bubble_fetch`=1 for 3 cycles without redirect: `inst_valid`=0, same head (`inst_pc`=0x20) presented when released.
- `ibus_err`=1 on fetch of 0x40: `inst_pc`=0x40 with `inst_fault`=1; 0x44 with `inst_fault`=0.
- Redirect to 0xFFFF_FFFE: fetches 0xFFFF_FFFC then wraps to 0x0000_0000.
